branch_predictor_btb: RTL and testbench
=======================================

Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer (BTB) with a 2-bit branch history table, for the 5-stage pipeline.
- IF stage: looks up the current PC combinationally and supplies a predicted next PC.
- EX stage: resolves the branch, updates the table on the clock edge, and raises a same-cycle redirect on misprediction.
- Replaces the current always-not-taken scheme, which flushes IF/ID and ID/EX on every taken branch; adds table flush and saturating performance counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_BITS, 4, log2(ENTRIES); index = pc[IDX_BITS+1:2].
- TAG_BITS, 26, tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; IDX_BITS+TAG_BITS ≤ 30.
- CNT_W, 16, width of each performance counter.
- INIT_CTR, 2'b01, counter value after reset/flush (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_pc  in  32  PC being fetched.
- pred_hit  out  1  valid entry with matching tag for if_pc.
- pred_taken  out  1  predict taken.
- pred_target  out  32  predicted next PC.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_pc  in  32  PC of EX instruction.
- ex_taken  in  1  resolved branch outcome.
- ex_target  in  32  resolved branch target.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  32  predicted PC carried down the pipe.
- flush_all  in  1  synchronous invalidate of all entries.
- mispredict  out  1  redirect required this cycle.
- redirect_pc  out  32  correct next PC when mispredict=1.
- br_count  out  CNT_W  resolved branches, saturating.
- mispred_count  out  CNT_W  mispredictions, saturating.

Behaviour:
- Entry state: valid, tag, target[31:0], ctr[1:0]. Storage is registers, so lookup is asynchronous.
- Lookup (combinational):
  - pred_hit = valid[idx] & (tag[idx] == if_pc tag).
  - pred_taken = pred_hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4. Addition is 32-bit and wraps.
- Mispredict (combinational from EX inputs, zero latency):
  - Branch case: ex_valid & ex_is_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
  - Alias case: ex_valid & !ex_is_branch & ex_pred_taken, i.e. a non-branch predicted taken.
  - redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4. redirect_pc is driven regardless of mispredict.
- Update on rising clk when ex_valid & ex_is_branch, with e = index/tag of ex_pc:
  - Hit: ctr saturating increment if taken, decrement if not; 11 stays 11 on taken, 00 stays 00 on not-taken. If taken, target <= ex_target.
  - Miss and taken: allocate (overwrite): valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not-taken: no change.
- Alias case: hit entry for ex_pc is invalidated (valid <= 0).
- ex_valid=0: no update, mispredict=0, counters unchanged.
- Same-cycle lookup and update on the same index: lookup returns pre-edge contents; the new value is visible the next cycle.
- flush_all=1: on the next edge all valid <= 0 and all ctr <= INIT_CTR.
  - Flush has priority over a simultaneous update.
  - Counters are not cleared by flush.
- Counters:
  - br_count += 1 per ex_valid & ex_is_branch cycle.
  - mispred_count += 1 per mispredict cycle.
  - Both saturate at all-ones and do not wrap.
- Reset (async assert, any time including mid-update):
  - All valid=0, ctr=INIT_CTR, tags/targets=0, counters=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=if_pc+4, br_count=mispred_count=0.
  - mispredict/redirect_pc remain combinational from the EX inputs.
  - Deassertion is taken synchronously on the next edge (reset is treated as synchronised externally).
- Synthesis: no latches; ENTRIES×(1+TAG_BITS+34) flops.

Test Plan:
- Cold miss: after reset, if_pc=0x00400010 -> pred_hit=0, pred_target=0x00400014. EX branch at 0x00400010, taken to 0x00400040, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x00400040. Next cycle lookup 0x00400010 -> hit, taken, target 0x00400040.
- Counter saturation: same branch resolved taken 3 more times, then not-taken once -> prediction remains taken (ctr 11->10). A second not-taken -> ctr=01, pred_taken=0; not-taken at 00 stays 00.
- Aliasing: ENTRIES=16, entry at 0x00400010 valid; non-branch at 0x00400010 in EX with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x00400014, entry invalidated. Conflicting tag 0x00400050 taken -> replaces entry, old PC then misses.
- Same-cycle: update and lookup on same index in one cycle -> lookup shows old entry, new entry visible next cycle. flush_all together with update -> all entries invalid afterwards.
- Counters: CNT_W=4, 20 branches all mispredicted -> br_count=mispred_count=4'hF, no wrap; ex_valid=0 cycles do not count.
- Reset mid-run: assert reset asynchronously between edges with a populated table -> pred_hit drops immediately; after release all lookups miss and counters read 0.

Source files
------------

// File: rtl/branch_predictor_btb.sv
//------------------------------------------------------------------------------
// branch_predictor_btb
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry, used by a 5-stage pipeline.
//
//   IF side  : if_pc is looked up combinationally. pred_hit / pred_taken /
//              pred_target give the next fetch PC (if_pc+4 unless the entry
//              predicts taken).
//   EX side  : the resolved instruction updates the table on the rising edge
//              and mispredict / redirect_pc flag a same-cycle redirect.
//   Control  : flush_all invalidates every entry on the next edge.
//   Stats    : br_count / mispred_count are saturating event counters.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   if_pc          in   PC being fetched
//   pred_hit       out  valid entry with matching tag for if_pc
//   pred_taken     out  predict taken
//   pred_target    out  predicted next PC
//   ex_valid       in   EX holds a real (non-bubble) instruction
//   ex_is_branch   in   EX instruction is a conditional branch
//   ex_pc          in   PC of EX instruction
//   ex_taken       in   resolved branch outcome
//   ex_target      in   resolved branch target
//   ex_pred_taken  in   prediction carried with the instruction
//   ex_pred_target in   predicted next PC carried with the instruction
//   flush_all      in   synchronous invalidate of all entries
//   mispredict     out  redirect required this cycle
//   redirect_pc    out  correct next PC (driven whenever EX inputs are)
//   br_count       out  resolved branches, saturating
//   mispred_count  out  mispredictions, saturating
//
// Qualifier semantics: the EX interface has no backpressure. ex_valid marks a
// cycle in which the EX fields describe a real instruction; every ex_* field
// other than ex_valid is ignored (no update, no count, no redirect) when
// ex_valid is low. There is no ready: the predictor accepts every valid cycle.
//
// The design has no FSM; all state is the entry table and the two counters.
//------------------------------------------------------------------------------
module branch_predictor_btb #(
   parameter int         ENTRIES  = 16,
   parameter int         IDX_BITS = 4,
   parameter int         TAG_BITS = 26,
   parameter int         CNT_W    = 16,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             reset,

   input  logic [31:0]      if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [31:0]      pred_target,

   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [31:0]      ex_pc,
   input  logic             ex_taken,
   input  logic [31:0]      ex_target,
   input  logic             ex_pred_taken,
   input  logic [31:0]      ex_pred_target,

   input  logic             flush_all,

   output logic             mispredict,
   output logic [31:0]      redirect_pc,

   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int TAG_LO = IDX_BITS + 2;
   localparam int TAG_HI = IDX_BITS + TAG_BITS + 1;

   //---------------------------------------------------------------------------
   // Entry storage. Kept in flops so the IF lookup is a pure mux.
   //---------------------------------------------------------------------------
   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [CNT_W-1:0]    br_count_q;
   logic [CNT_W-1:0]    mispred_count_q;

   //---------------------------------------------------------------------------
   // Address split
   //---------------------------------------------------------------------------
   logic [IDX_BITS-1:0] if_idx;
   logic [TAG_BITS-1:0] if_tag;
   logic [IDX_BITS-1:0] ex_idx;
   logic [TAG_BITS-1:0] ex_tag;

   assign if_idx = if_pc[IDX_BITS+1:2];
   assign if_tag = if_pc[TAG_HI:TAG_LO];
   assign ex_idx = ex_pc[IDX_BITS+1:2];
   assign ex_tag = ex_pc[TAG_HI:TAG_LO];

   // The byte-offset bits (and any PC bits above the tag) never select an
   // entry; they are collected here so they are visibly intentional.
   logic unused_pc_bits;
   generate
      if (TAG_HI < 31) begin : g_unused_hi
         assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0],
                                   if_pc[31:TAG_HI+1], ex_pc[31:TAG_HI+1]};
      end else begin : g_unused_lo
         assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};
      end
   endgenerate

   //---------------------------------------------------------------------------
   // IF lookup. Reads pre-edge contents, so an update to the same index in the
   // same cycle only becomes visible on the following cycle.
   //---------------------------------------------------------------------------
   logic [31:0] if_pc_plus4;

   assign if_pc_plus4 = if_pc + 32'd4;
   assign pred_hit    = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
   assign pred_taken  = pred_hit & ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : if_pc_plus4;

   //---------------------------------------------------------------------------
   // EX resolution
   //---------------------------------------------------------------------------
   logic ex_hit;
   logic ex_update;
   logic branch_mispredict;
   logic alias_mispredict;

   assign ex_hit    = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
   assign ex_update = ex_valid & ex_is_branch;

   // A branch is mispredicted if the direction was wrong, or if it was taken
   // to a target other than the one fetch went to.
   assign branch_mispredict = ex_update &
                              ((ex_taken != ex_pred_taken) |
                               (ex_taken & (ex_pred_target != ex_target)));

   // A non-branch that fetch predicted taken: its PC aliases onto a branch
   // entry (or the entry is stale), so fetch went down a bogus path.
   assign alias_mispredict = ex_valid & ~ex_is_branch & ex_pred_taken;

   assign mispredict  = branch_mispredict | alias_mispredict;
   assign redirect_pc = (ex_is_branch & ex_taken) ? ex_target : (ex_pc + 32'd4);

   // Saturating 2-bit direction counter step.
   logic [1:0] ctr_cur;
   logic [1:0] ctr_next;

   assign ctr_cur = ctr_q[ex_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (ex_taken) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
      end
   end

   //---------------------------------------------------------------------------
   // Table update. Priority: reset, flush, branch update, alias invalidate.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= INIT_CTR;
         end
      end else if (flush_all) begin
         // Tags and targets are left alone: with valid cleared they are dead.
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= INIT_CTR;
         end
      end else if (ex_update) begin
         if (ex_hit) begin
            ctr_q[ex_idx] <= ctr_next;
            if (ex_taken) target_q[ex_idx] <= ex_target;
         end else if (ex_taken) begin
            // Allocate over whatever occupied the slot; start weakly taken.
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
            ctr_q[ex_idx]    <= 2'b10;
         end
      end else if (alias_mispredict && ex_hit) begin
         valid_q[ex_idx] <= 1'b0;
      end
   end

   //---------------------------------------------------------------------------
   // Performance counters. Not affected by flush_all; stick at all-ones.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         if (ex_update && (br_count_q != {CNT_W{1'b1}}))
            br_count_q <= br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (mispredict && (mispred_count_q != {CNT_W{1'b1}}))
            mispred_count_q <= mispred_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
//------------------------------------------------------------------------------
// tb_branch_predictor_btb
//
// Directed scenarios with literal expectations, then a randomized run, all
// checked every cycle against a table model in the bench. The DUT is built
// with 4-bit counters so saturation is reachable in a short run.
//------------------------------------------------------------------------------
module tb_branch_predictor_btb;

   localparam int CNT_W = 4;
   localparam int NENT  = 16;
   localparam int MAXC  = (1 << CNT_W) - 1;

   //---------------------------------------------------------------------------
   // Clock / reset
   //---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [31:0]      if_pc;
   logic             pred_hit, pred_taken;
   logic [31:0]      pred_target;
   logic             ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
   logic [31:0]      ex_pc, ex_target, ex_pred_target;
   logic             flush_all;
   logic             mispredict;
   logic [31:0]      redirect_pc;
   logic [CNT_W-1:0] br_count, mispred_count;

   branch_predictor_btb #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
      .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
      .ex_taken(ex_taken), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .flush_all(flush_all),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   //---------------------------------------------------------------------------
   // Reference model: a table indexed by (pc/4) mod 16, tag = pc/64,
   // direction confidence as an integer 0..3 (taken when >= 2).
   //---------------------------------------------------------------------------
   bit          m_valid [NENT];
   logic [31:0] m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   int          m_br, m_mis;

   int vectors = 0;
   int errors  = 0;
   logic [CNT_W-1:0] exp_q[$];

   function automatic void m_reset();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
      end
      m_br = 0; m_mis = 0;
   endfunction

   function automatic int m_index(input logic [31:0] pc);
      return int'((pc >> 2) % 32'd16);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == (pc >> 6));
   endfunction

   function automatic void m_look(input logic [31:0] pc, output bit hit,
                                  output bit tk, output logic [31:0] tgt);
      hit = m_hit(pc);
      tk  = hit && (m_ctr[m_index(pc)] >= 2);
      tgt = tk ? m_tgt[m_index(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mispredict();
      if (!ex_valid) return 1'b0;
      if (ex_is_branch)
         return (ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target));
      return ex_pred_taken;
   endfunction

   function automatic void m_update();
      int  i   = m_index(ex_pc);
      bit  hit = m_hit(ex_pc);
      if (ex_valid && ex_is_branch && m_br < MAXC) m_br++;
      if (m_mispredict() && m_mis < MAXC) m_mis++;
      if (flush_all) begin
         for (int k = 0; k < NENT; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; end
      end else if (ex_valid && ex_is_branch) begin
         if (hit) begin
            m_ctr[i] = ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (ex_taken) m_tgt[i] = ex_target;
         end else if (ex_taken) begin
            m_valid[i] = 1'b1; m_tag[i] = ex_pc >> 6; m_tgt[i] = ex_target; m_ctr[i] = 2;
         end
      end else if (ex_valid && ex_pred_taken && hit) begin
         m_valid[i] = 1'b0;
      end
   endfunction

   //---------------------------------------------------------------------------
   // Checking
   //---------------------------------------------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Mid-cycle compare of every output against the model.
   task automatic settle();
      bit          h, t;
      logic [31:0] g;
      #3;
      m_look(if_pc, h, t, g);
      chk("pred_hit",    {31'd0, pred_hit},   {31'd0, h});
      chk("pred_taken",  {31'd0, pred_taken}, {31'd0, t});
      chk("pred_target", pred_target, g);
      chk("mispredict",  {31'd0, mispredict}, {31'd0, m_mispredict()});
      chk("redirect_pc", redirect_pc,
          (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4);
      exp_q.push_back(CNT_W'(m_br));
      exp_q.push_back(CNT_W'(m_mis));
      chk("br_count",      {28'd0, br_count},      {28'd0, exp_q.pop_front()});
      chk("mispred_count", {28'd0, mispred_count}, {28'd0, exp_q.pop_front()});
   endtask

   // Advance one edge; the model follows the inputs held across it.
   task automatic tick();
      @(posedge clk);
      if (reset) m_update();
      #1;
   endtask

   //---------------------------------------------------------------------------
   // Drivers
   //---------------------------------------------------------------------------
   task automatic set_ex(input bit v, input bit br, input logic [31:0] pc,
                         input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
      ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
      ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
   endtask

   task automatic idle();
      set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] pool_pc();
      return 32'h0040_0000 | (32'($urandom_range(0, 2)) << 6)
                           | (32'($urandom_range(0, 15)) << 2);
   endfunction

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   localparam logic [31:0] PA = 32'h0040_0010;
   localparam logic [31:0] TA = 32'h0040_0040;
   localparam logic [31:0] PB = 32'h0040_0050;
   localparam logic [31:0] TB = 32'h0040_0080;
   localparam logic [31:0] PC = 32'h0040_0090;

   initial begin
      reset = 1'b0; flush_all = 1'b0; if_pc = 32'h0; idle(); m_reset();
      settle();
      chk("reset_pred_target", pred_target, 32'h0000_0004);
      tick();
      reset = 1'b1;

      // Cold miss, allocate.
      if_pc = PA;
      set_ex(1, 1, PA, 1, TA, 0, 32'h0);
      settle();
      chk("cold_hit", {31'd0, pred_hit}, 32'd0);
      chk("cold_pred_target", pred_target, 32'h0040_0014);
      chk("cold_mispredict", {31'd0, mispredict}, 32'd1);
      chk("cold_redirect", redirect_pc, TA);
      tick();

      // Three more taken: 10 -> 11 -> 11 -> 11.
      set_ex(1, 1, PA, 1, TA, 1, TA);
      settle();
      chk("alloc_hit", {31'd0, pred_hit}, 32'd1);
      chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
      chk("alloc_target", pred_target, TA);
      tick();
      repeat (2) begin settle(); tick(); end

      // Not-taken: 11 -> 10 (still predicts taken).
      set_ex(1, 1, PA, 0, TA, 1, TA);
      settle();
      chk("nt_mispredict", {31'd0, mispredict}, 32'd1);
      chk("nt_redirect", redirect_pc, 32'h0040_0014);
      tick();
      settle();
      chk("ctr10_taken", {31'd0, pred_taken}, 32'd1);
      tick();                                   // 10 -> 01
      set_ex(1, 1, PA, 0, TA, 0, 32'h0);
      settle();
      chk("ctr01_taken", {31'd0, pred_taken}, 32'd0);
      chk("ctr01_hit", {31'd0, pred_hit}, 32'd1);
      chk("ctr01_target", pred_target, 32'h0040_0014);
      tick();                                   // 01 -> 00
      settle(); tick();                         // 00 stays 00
      set_ex(1, 1, PA, 1, TA, 0, 32'h0);
      settle(); tick();                         // 00 -> 01
      idle();
      settle();
      chk("ctr_floor_taken", {31'd0, pred_taken}, 32'd0);
      tick();

      // Alias: non-branch predicted taken invalidates the entry.
      set_ex(1, 0, PA, 0, 32'h0, 1, TA);
      settle();
      chk("alias_mispredict", {31'd0, mispredict}, 32'd1);
      chk("alias_redirect", redirect_pc, 32'h0040_0014);
      tick();
      set_ex(1, 1, PA, 1, TA, 0, 32'h0);
      settle();
      chk("alias_invalid", {31'd0, pred_hit}, 32'd0);
      chk("mid_br_count", {28'd0, br_count}, 32'd9);
      chk("mid_mispred_count", {28'd0, mispred_count}, 32'd5);
      tick();

      // Conflicting tag on the same index; lookup sees the old entry this cycle.
      set_ex(1, 1, PB, 1, TB, 0, 32'h0);
      settle();
      chk("same_cycle_old_hit", {31'd0, pred_hit}, 32'd1);
      chk("same_cycle_old_target", pred_target, TA);
      tick();
      idle();
      settle();
      chk("replaced_old_miss", {31'd0, pred_hit}, 32'd0);
      tick();
      if_pc = PB;
      settle();
      chk("replaced_new_target", pred_target, TB);
      tick();

      // Flush with a simultaneous allocate: flush wins.
      flush_all = 1'b1;
      set_ex(1, 1, PC, 1, 32'h0040_00C0, 0, 32'h0);
      settle(); tick();
      flush_all = 1'b0; idle();
      if_pc = PC;
      settle();
      chk("flush_beats_update", {31'd0, pred_hit}, 32'd0);
      tick();
      if_pc = PB;
      settle();
      chk("flush_clears", {31'd0, pred_hit}, 32'd0);
      tick();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         bit          h, t;
         logic [31:0] g, epc, etgt;
         int          sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      if_pc = $urandom & 32'hFFFF_FFFC;
         else if (sel == 1) if_pc = 32'hFFFF_FFFC;
         else               if_pc = pool_pc();
         epc  = ($urandom_range(0, 3) == 0) ? if_pc : pool_pc();
         etgt = ($urandom_range(0, 1) == 0) ? pool_pc() : epc + 32'd4;
         m_look(epc, h, t, g);
         if ($urandom_range(0, 9) < 7)
            set_ex($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, epc,
                   1'($urandom_range(0, 1)), etgt, t, g);
         else
            set_ex($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, epc,
                   1'($urandom_range(0, 1)), etgt, 1'($urandom_range(0, 1)), pool_pc());
         flush_all = ($urandom_range(0, 99) == 0);
         settle();
         tick();
      end
      flush_all = 1'b0;

      // Asynchronous reset between edges with a populated table.
      if_pc = 32'h0040_0100;
      set_ex(1, 1, 32'h0040_0100, 1, 32'h0040_0200, 0, 32'h0);
      settle(); tick();
      idle();
      settle();
      chk("pre_reset_hit", {31'd0, pred_hit}, 32'd1);
      #1 reset = 1'b0;
      #1;
      m_reset();
      chk("async_reset_hit", {31'd0, pred_hit}, 32'd0);
      chk("async_reset_br", {28'd0, br_count}, 32'd0);
      chk("async_reset_target", pred_target, 32'h0040_0104);
      tick();
      reset = 1'b1;
      settle();
      chk("post_reset_miss", {31'd0, pred_hit}, 32'd0);
      chk("post_reset_mis", {28'd0, mispred_count}, 32'd0);
      tick();

      // 20 mispredicted branches with gated bubbles between them.
      for (int n = 0; n < 20; n++) begin
         set_ex(1, 1, pool_pc(), 1, pool_pc(), 0, 32'h0);
         settle(); tick();
         set_ex(0, 1, pool_pc(), 1, pool_pc(), 0, 32'h0);
         settle(); tick();
         if (n == 9) begin
            chk("cnt10_br", {28'd0, br_count}, 32'd10);
            chk("cnt10_mis", {28'd0, mispred_count}, 32'd10);
         end
      end
      idle();
      settle();
      chk("sat_br_count", {28'd0, br_count}, 32'hF);
      chk("sat_mispred_count", {28'd0, mispred_count}, 32'hF);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
